// File: rtl/data_memory_responder.sv
// Fixed-latency byte-addressable data memory answering the CPU MEM stage.
// Requests are latched in IDLE; the access commits on the last WAIT edge and is acknowledged for one cycle.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          rd_q, wr_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          request, done, fault;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word, shifted, load_val, store_val;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;
  logic [3:0]    be;
  logic          unused_addr;

  assign unused_addr = ^ADDRESS[31:AW+2];
  assign request     = READ | WRITE;
  assign done        = (state == WAIT) && (cnt == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (request) next_state = WAIT;
      WAIT:    if (cnt == '0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT = (state == WAIT) || ((state == IDLE) && request);
  end

  // Decode of the latched request: fault detection, load extraction, store lane merge.
  always_comb begin
    idx      = addr_q[AW+1:2];
    lane     = addr_q[1:0];
    word     = mem[idx];
    shifted  = word >> {lane, 3'b000};
    byte_val = shifted[7:0];
    half_val = lane[1] ? word[31:16] : word[15:0];

    fault = rd_q & wr_q;
    if (rd_q && (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111)) fault = 1'b1;
    if (wr_q && (f3_q[2] || f3_q[1:0] == 2'b11)) fault = 1'b1;
    if (f3_q[1:0] == 2'b01 && lane[0]) fault = 1'b1;
    if (f3_q[1:0] == 2'b10 && lane != 2'b00) fault = 1'b1;

    case (f3_q)
      3'b000:  load_val = {{24{byte_val[7]}}, byte_val};
      3'b001:  load_val = {{16{half_val[15]}}, half_val};
      3'b100:  load_val = {24'd0, byte_val};
      3'b101:  load_val = {16'd0, half_val};
      default: load_val = word;
    endcase

    case (f3_q[1:0])
      2'b00: begin
        store_val = {4{wdata_q[7:0]}};
        be        = 4'b0001 << lane;
      end
      2'b01: begin
        store_val = {2{wdata_q[15:0]}};
        be        = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_val = wdata_q;
        be        = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      READDATA <= '0;
      ERROR    <= 1'b0;
    end else begin
      ERROR <= 1'b0;
      if (state == IDLE && request) begin
        rd_q    <= READ;
        wr_q    <= WRITE;
        addr_q  <= ADDRESS[AW+1:0];
        wdata_q <= WRITEDATA;
        f3_q    <= FUNC3;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        ERROR <= fault;
        if (fault)     READDATA <= '0;
        else if (rd_q) READDATA <= load_val;
      end
    end
  end

  // Storage has no reset; a reset mid-WAIT forces IDLE so the pending store never commits.
  always_ff @(posedge CLK) begin
    if (done && wr_q && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= store_val[i*8 +: 8];
      end
    end
  end
endmodule
